region_colour_probe: RTL and testbench
======================================

# region_colour_probe

Framebuffer read-side block: on request, scans a rectangular region of the 360x240 screen memory, one pixel read per cycle in column-major order, and reports whether any pixel equals a target colour. It is the reader counterpart to the screen-fill and sprite pixel writers. It drives the framebuffer read port and feeds game logic that needs collision and landing checks, for example marshmallow against obstacle colour.

## Interface
- SCR_W, 360, screen width; x >= SCR_W is off-screen.
- SCR_H, 240, screen height; y >= SCR_H is off-screen.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request pulse; sampled only when idle.
- x0  in  9  region left column.
- y0  in  8  region top row.
- w  in  6  region width in pixels, 0..63.
- h  in  6  region height in pixels, 0..63.
- target  in  3  colour to match.
- rd_en  out  1  framebuffer read strobe.
- rd_x  out  9  read column.
- rd_y  out  8  read row.
- rd_colour  in  3  read data, valid exactly 1 cycle after the rd_en cycle.
- busy  out  1  scan in progress.
- done  out  1  one-cycle completion pulse.
- hit  out  1  a match was found.
- hit_x  out  9  column of the first match.
- hit_y  out  8  row of the first match.

## Operation
- States are IDLE, SCAN and DRAIN.
  - SCAN issues reads.
  - DRAIN waits for the final in-flight read.
- start accepted in IDLE:
  - latch x0, y0, w, h and target;
  - clear hit, hit_x and hit_y;
  - enter SCAN with column index i=0, row index j=0.
- start is ignored while busy.
- Scan order: pixel k = i*h + j; j is the inner index (column-major), i is the outer index. Read address = (x0+i, y0+j).
- Coordinate sums use 10-bit (x) and 9-bit (y) arithmetic. There is no wrap-around.
- Off-screen slot (x >= 360 or y >= 240):
  - rd_en low, slot still consumes one cycle;
  - the pixel counts as no match.
- Compare path:
  - rd_en is delayed one cycle as a valid bit, together with the address.
  - A match requires valid & (rd_colour == target).
  - Stale data on rd_colour must never match.
- First match:
  - register hit=1, hit_x/hit_y = that pixel's address;
  - stop issuing reads immediately;
  - the one read already in flight is discarded;
  - return to IDLE with done.
- No match after the last pixel's data: hit=0, done, IDLE.
- w==0 or h==0: no reads, hit=0, done.
- SCAN moves to DRAIN after the last slot (i=w-1, j=h-1) is issued. DRAIN moves to IDLE after its data has been compared.
- hit, hit_x and hit_y hold until the next accepted start.
- busy = (state != IDLE).

## Timing
- Reset values:
  - state IDLE;
  - rd_en=0, rd_x=0, rd_y=0;
  - busy=0, done=0, hit=0, hit_x=0, hit_y=0;
  - the internal valid pipeline is cleared.
- Cycle reference: E0 is the edge that accepts start.
- Reads: read k is presented after edge Ek, one per cycle, no gaps, for k = 0 .. n-1 with n = w*h.
- Outputs rd_x, rd_y, rd_en, busy, done and hit are all registered.
- Done timing:
  - no match: done high in the cycle after E(n+1);
  - first match at pixel k: done high in the cycle after E(k+2); rd_en is low from E(k+2) onward, so read k+1 is the only extra read;
  - w or h zero: done after E1.
- During the done cycle the block is already IDLE with busy=0, and a start in that cycle is accepted.
- Reset asserted mid-scan: reset values on the next edge; in-flight data is ignored; no done pulse.

## Test plan
- Reset behaviour: assert reset during an active scan -> next cycle all outputs are 0; later rd_colour activity is ignored; no done.
- 2x2 region, all black: x0=10, y0=20, target=3'b011, memory all 3'b000.
  - Reads (10,20), (10,21), (11,20), (11,21) on consecutive cycles.
  - done after E5, hit=0.
- Early hit in a 3x3 region: x0=10, y0=20, pixel (11,20) is 3'b011 (k=3).
  - Exactly reads k=0..4 are issued.
  - done after E5, hit=1, hit_x=11, hit_y=20.
- Clipping: x0=358, y0=238, w=4, h=4, no match.
  - Only 4 rd_en pulses: x in {358,359}, y in {238,239}.
  - rd_en low in the other 12 slots.
  - done after E17.
  - A match placed at x=360 in the memory model is never reported.
- Zero-size region: w=0 -> done after E1, hit=0, rd_en never high.
- Handshake and hold:
  - start while busy -> ignored; the parameters do not change.
  - start during the done cycle -> accepted; new reads begin the next cycle.
  - Previous hit is cleared at that accepting edge.

Source files
------------

// File: rtl/region_colour_probe.sv
// Scans a w x h framebuffer region column-major, one read per cycle, and reports the first pixel equal to target.
// Latency: done n+1 cycles after start, or k+2 after a match at pixel k; start is ignored while busy.
module region_colour_probe #(
    parameter int SCR_W = 360,
    parameter int SCR_H = 240
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [8:0] x0_i,
    input  logic [7:0] y0_i,
    input  logic [5:0] w_i,
    input  logic [5:0] h_i,
    input  logic [2:0] target_i,
    output logic       rd_en_o,
    output logic [8:0] rd_x_o,
    output logic [7:0] rd_y_o,
    input  logic [2:0] rd_colour_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       hit_o,
    output logic [8:0] hit_x_o,
    output logic [7:0] hit_y_o
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t     state_q, state_d;
    logic [8:0] x0_q, x0_d;
    logic [7:0] y0_q, y0_d;
    logic [5:0] w_q, w_d, h_q, h_d;
    logic [2:0] tgt_q, tgt_d;
    logic [5:0] i_q, i_d, j_q, j_d;
    logic       rd_en_q, rd_en_d;
    logic [8:0] rd_x_q, rd_x_d;
    logic [7:0] rd_y_q, rd_y_d;
    logic       vld_q, vld_d;
    logic [8:0] vx_q, vx_d;
    logic [7:0] vy_q, vy_d;
    logic       done_q, done_d;
    logic       hit_q, hit_d;
    logic [8:0] hit_x_q, hit_x_d;
    logic [7:0] hit_y_q, hit_y_d;

    logic       col_end, last_slot, match;
    logic [5:0] nxt_i, nxt_j;
    logic [9:0] sum_x;
    logic [8:0] sum_y;

    function automatic logic on_screen(input logic [9:0] x, input logic [8:0] y);
        return (x < 10'(SCR_W)) && (y < 9'(SCR_H));
    endfunction

    assign col_end   = (j_q == h_q - 6'd1);
    assign last_slot = col_end && (i_q == w_q - 6'd1);
    assign nxt_i     = col_end ? i_q + 6'd1 : i_q;
    assign nxt_j     = col_end ? 6'd0 : j_q + 6'd1;
    assign sum_x     = {1'b0, x0_q} + {4'd0, nxt_i};
    assign sum_y     = {1'b0, y0_q} + {3'd0, nxt_j};
    // Only data tagged by the delayed read strobe may match; idle-bus values never count.
    assign match     = vld_q && (rd_colour_i == tgt_q);

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        tgt_d   = tgt_q;
        i_d     = i_q;
        j_d     = j_q;
        rd_en_d = 1'b0;
        rd_x_d  = rd_x_q;
        rd_y_d  = rd_y_q;
        vld_d   = rd_en_q;
        vx_d    = rd_x_q;
        vy_d    = rd_y_q;
        done_d  = 1'b0;
        hit_d   = hit_q;
        hit_x_d = hit_x_q;
        hit_y_d = hit_y_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    x0_d    = x0_i;
                    y0_d    = y0_i;
                    w_d     = w_i;
                    h_d     = h_i;
                    tgt_d   = target_i;
                    i_d     = 6'd0;
                    j_d     = 6'd0;
                    hit_d   = 1'b0;
                    hit_x_d = 9'd0;
                    hit_y_d = 8'd0;
                    if (w_i == 6'd0 || h_i == 6'd0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = SCAN;
                        rd_en_d = on_screen({1'b0, x0_i}, {1'b0, y0_i});
                        rd_x_d  = x0_i;
                        rd_y_d  = y0_i;
                    end
                end
            end
            SCAN: begin
                if (match) begin
                    hit_d   = 1'b1;
                    hit_x_d = vx_q;
                    hit_y_d = vy_q;
                    done_d  = 1'b1;
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end else if (last_slot) begin
                    state_d = DRAIN;
                end else begin
                    i_d     = nxt_i;
                    j_d     = nxt_j;
                    rd_en_d = on_screen(sum_x, sum_y);
                    rd_x_d  = sum_x[8:0];
                    rd_y_d  = sum_y[7:0];
                end
            end
            DRAIN: begin
                if (match) begin
                    hit_d   = 1'b1;
                    hit_x_d = vx_q;
                    hit_y_d = vy_q;
                end
                done_d  = 1'b1;
                vld_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            tgt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            rd_en_q <= 1'b0;
            rd_x_q  <= '0;
            rd_y_q  <= '0;
            vld_q   <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            hit_x_q <= '0;
            hit_y_q <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            tgt_q   <= tgt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rd_en_q <= rd_en_d;
            rd_x_q  <= rd_x_d;
            rd_y_q  <= rd_y_d;
            vld_q   <= vld_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            hit_x_q <= hit_x_d;
            hit_y_q <= hit_y_d;
        end
    end

    assign rd_en_o = rd_en_q;
    assign rd_x_o  = rd_x_q;
    assign rd_y_o  = rd_y_q;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign hit_o   = hit_q;
    assign hit_x_o = hit_x_q;
    assign hit_y_o = hit_y_q;

endmodule

// File: tb/tb_region_colour_probe.sv
// Bench for region_colour_probe: a framebuffer model answers reads and a scoreboard holds expected reads and results.
module tb_region_colour_probe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] x0 = '0;
    logic [7:0] y0 = '0;
    logic [5:0] w = '0;
    logic [5:0] h = '0;
    logic [2:0] target = '0;
    logic [2:0] rd_colour = '0;
    logic       rd_en, busy, done, hit;
    logic [8:0] rd_x, hit_x;
    logic [7:0] rd_y, hit_y;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int e0 = 0;

    typedef struct { int x; int y; int c; } rd_t;
    typedef struct { int c; logic hit; int hx; int hy; } res_t;
    rd_t  exp_rd[$];
    res_t exp_res[$];

    logic [2:0] mem [512][256];
    logic [2:0] stale_col = 3'd0;
    logic       pend = 1'b0;
    logic [8:0] px = '0;
    logic [7:0] py = '0;

    region_colour_probe dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .x0_i(x0), .y0_i(y0), .w_i(w), .h_i(h), .target_i(target),
        .rd_en_o(rd_en), .rd_x_o(rd_x), .rd_y_o(rd_y), .rd_colour_i(rd_colour),
        .busy_o(busy), .done_o(done), .hit_o(hit), .hit_x_o(hit_x), .hit_y_o(hit_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Framebuffer: data for the read strobed in the previous cycle, otherwise a stale bus value.
    always @(posedge clk) begin
        #1;
        rd_colour = pend ? mem[px][py] : stale_col;
        pend = (rd_en === 1'b1);
        px = rd_x;
        py = rd_y;
    end

    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            total++;
            if (exp_rd.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read: got (%0d,%0d) at cycle %0d, expected no read", rd_x, rd_y, cyc);
            end else begin
                rd_t e;
                e = exp_rd.pop_front();
                if (rd_x !== e.x[8:0] || rd_y !== e.y[7:0] || cyc != e.c) begin
                    bad++;
                    $display("FAIL read_addr: got (%0d,%0d)@%0d, expected (%0d,%0d)@%0d",
                             rd_x, rd_y, cyc, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic mem_clear();
        for (int xi = 0; xi < 512; xi++)
            for (int yi = 0; yi < 256; yi++)
                mem[xi][yi] = 3'd0;
    endtask

    // Drive a start (caller sits just after a negedge), then push the reference read stream and result.
    task automatic launch(input int lx, input int ly, input int lw, input int lh, input int lt);
        int   n, hk;
        logic found;
        res_t r;
        x0 = lx[8:0]; y0 = ly[7:0]; w = lw[5:0]; h = lh[5:0]; target = lt[2:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0 = cyc;
        n = lw * lh;
        found = 1'b0;
        hk = 0;
        for (int k = 0; k < n && !found; k++) begin
            int xx, yy;
            xx = lx + k / lh;
            yy = ly + k % lh;
            if (xx < 360 && yy < 240) begin
                exp_rd.push_back('{xx, yy, e0 + k});
                if (mem[xx][yy] == lt[2:0]) begin
                    found = 1'b1;
                    hk = k;
                    r.hx = xx;
                    r.hy = yy;
                end
            end
        end
        if (found && hk + 1 < n) begin
            int xn, yn;
            xn = lx + (hk + 1) / lh;
            yn = ly + (hk + 1) % lh;
            if (xn < 360 && yn < 240) exp_rd.push_back('{xn, yn, e0 + hk + 1});
        end
        r.hit = found;
        if (!found) begin r.hx = 0; r.hy = 0; end
        r.c = (n == 0) ? e0 + 1 : (found ? e0 + hk + 2 : e0 + n + 1);
        exp_res.push_back(r);
    endtask

    // Returns just after the negedge of the done cycle.
    task automatic wait_done(input string name);
        int   n;
        res_t r;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 300);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: done never seen, expected done", name);
            exp_rd.delete();
            exp_res.delete();
            return;
        end
        r = exp_res.pop_front();
        total += 5;
        if (cyc != r.c) begin
            bad++;
            $display("FAIL %s_done_cycle: got %0d, expected %0d", name, cyc - e0, r.c - e0);
        end
        if (hit !== r.hit) begin
            bad++;
            $display("FAIL %s_hit: got %0b, expected %0b", name, hit, r.hit);
        end
        if (hit_x !== r.hx[8:0] || hit_y !== r.hy[7:0]) begin
            bad++;
            $display("FAIL %s_hit_xy: got (%0d,%0d), expected (%0d,%0d)", name, hit_x, hit_y, r.hx, r.hy);
        end
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_at_done: got %0b, expected 0", name, busy);
        end
        if (exp_rd.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_reads: got %0d outstanding, expected 0", name, exp_rd.size());
            exp_rd.delete();
        end
    endtask

    task automatic test_reset();
        logic [44:0] outs;
        repeat (3) @(negedge clk);
        outs = {rd_en, rd_x, rd_y, busy, done, hit, hit_x, hit_y};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_init: got %h, expected 0", outs);
        end
        rst = 1'b0;
        mem_clear();
        stale_col = 3'd3;
        mem[11][20] = 3'd3;
        @(negedge clk);
        launch(10, 20, 4, 4, 3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_rd.delete();
        exp_res.delete();
        outs = {rd_en, rd_x, rd_y, busy, done, hit, hit_x, hit_y};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_midscan: got %h, expected 0", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen_done, seen_hit;
            seen_done = 0;
            seen_hit = 0;
            repeat (20) begin
                @(negedge clk);
                if (done !== 1'b0) seen_done++;
                if (hit !== 1'b0) seen_hit++;
            end
            total += 2;
            if (seen_done != 0) begin
                bad++;
                $display("FAIL reset_no_done: got %0d done cycles, expected 0", seen_done);
            end
            if (seen_hit != 0) begin
                bad++;
                $display("FAIL reset_no_hit: got %0d hit cycles, expected 0", seen_hit);
            end
        end
    endtask

    task automatic test_all_black();
        mem_clear();
        @(negedge clk);
        launch(10, 20, 2, 2, 3);
        wait_done("all_black");
    endtask

    task automatic test_early_hit();
        mem_clear();
        mem[11][20] = 3'd3;
        @(negedge clk);
        launch(10, 20, 3, 3, 3);
        wait_done("early_hit");
        total++;
        if (hit !== 1'b1 || hit_x !== 9'd11 || hit_y !== 8'd20 || cyc - e0 != 5) begin
            bad++;
            $display("FAIL early_hit_fixed: got hit=%0b (%0d,%0d) latency %0d, expected 1 (11,20) 5",
                     hit, hit_x, hit_y, cyc - e0);
        end
    endtask

    task automatic test_clipping();
        mem_clear();
        mem[360][238] = 3'd3;
        mem[360][239] = 3'd3;
        @(negedge clk);
        launch(358, 238, 4, 4, 3);
        wait_done("clipping");
    endtask

    task automatic test_zero_size();
        @(negedge clk);
        launch(10, 20, 0, 5, 3);
        wait_done("zero_w");
        @(negedge clk);
        launch(10, 20, 5, 0, 3);
        wait_done("zero_h");
    endtask

    task automatic test_back_to_back();
        mem_clear();
        mem[11][21] = 3'd5;
        mem[100][100] = 3'd0;
        @(negedge clk);
        launch(10, 20, 3, 3, 5);
        @(negedge clk);
        x0 = 9'd100; y0 = 8'd100; w = 6'd1; h = 6'd1; target = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        launch(20, 30, 2, 2, 5);
        total++;
        if (hit !== 1'b0 || hit_x !== 9'd0 || hit_y !== 8'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_clear: got hit=%0b (%0d,%0d) busy=%0b, expected 0 (0,0) 1",
                     hit, hit_x, hit_y, busy);
        end
        wait_done("done_cycle_start");
    endtask

    initial begin
        test_reset();
        test_all_black();
        test_early_hit();
        test_clipping();
        test_zero_size();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
